// File: rtl/bus_arbiter_param.sv
// rtl/bus_arbiter_param.sv - parameterized bus arbiter: fixed/round-robin priority,
// tenure timeout, split retry and windowed bus utilization.
module bus_arbiter_param #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 64,
  parameter int WIN_LOG2    = 8,
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] requests,
  input  logic                   mode,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   bus_busy,
  output logic [IDW-1:0]         master_id,
  output logic [WIN_LOG2:0]      utilization,
  output logic                   util_valid
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]          HOLD_SAT = HW'((MAX_HOLD > 0) ? MAX_HOLD : 1);
  localparam logic [IDW-1:0]         LAST_ID  = IDW'(NUM_MASTERS - 1);
  localparam logic [IDW:0]           NM_W     = (IDW + 1)'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q, state_d;
  logic [IDW-1:0]           rr_ptr;
  logic [HW-1:0]            hold_cnt;
  logic                     split_pend;
  logic [IDW-1:0]           split_id;
  logic [NUM_MASTERS-1:0]   to_mask;
  logic [WIN_LOG2-1:0]      win_cnt;
  logic [WIN_LOG2:0]        acc;

  logic [NUM_MASTERS-1:0]   eligible;
  logic [IDW-1:0]           start;
  logic [IDW:0]             idx_w;
  logic                     found;
  logic [IDW-1:0]           win_idx;
  logic                     owner_req;
  logic                     timeout;

  assign bus_busy = |grant;

  // A split master sits out while its slave is still busy; once the slave frees
  // up it overrides the normal priority search.
  always_comb begin
    eligible = requests & ~to_mask;
    if (split_pend && slave_busy) eligible[split_id] = 1'b0;
    start   = mode ? ((rr_ptr == LAST_ID) ? '0 : rr_ptr + IDW'(1)) : '0;
    found   = 1'b0;
    win_idx = '0;
    idx_w   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx_w = {1'b0, start} + (IDW + 1)'(i);
      if (idx_w >= NM_W) idx_w = idx_w - NM_W;
      if (!found && eligible[idx_w[IDW-1:0]]) begin
        found   = 1'b1;
        win_idx = idx_w[IDW-1:0];
      end
    end
    if (split_pend && !slave_busy && requests[split_id]) begin
      found   = 1'b1;
      win_idx = split_id;
    end
  end

  always_comb begin
    owner_req = |(requests & grant);
    timeout   = (MAX_HOLD > 0) && (hold_cnt == HOLD_SAT) && (|(requests & ~grant));
    state_d   = state_q;
    case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (!owner_req || slave_busy || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant      <= '0;
      master_id  <= '0;
      rr_ptr     <= LAST_ID;
      hold_cnt   <= '0;
      split_pend <= 1'b0;
      split_id   <= '0;
      to_mask    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          to_mask <= '0;
          if (split_pend && !slave_busy) split_pend <= 1'b0;
          if (found) begin
            grant     <= ONE_HOT0 << win_idx;
            master_id <= win_idx;
            rr_ptr    <= win_idx;
            hold_cnt  <= HW'(1);
          end
        end
        BUSY: begin
          // Voluntary release outranks split, which outranks timeout.
          if (!owner_req) begin
            grant <= '0;
          end else if (slave_busy) begin
            grant      <= '0;
            split_pend <= 1'b1;
            split_id   <= master_id;
          end else if (timeout) begin
            grant   <= '0;
            to_mask <= grant;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: grant <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_cnt     <= '0;
      acc         <= '0;
      utilization <= '0;
      util_valid  <= 1'b0;
    end else begin
      win_cnt <= win_cnt + WIN_LOG2'(1);
      if (&win_cnt) begin
        utilization <= acc + {{WIN_LOG2{1'b0}}, bus_busy};
        util_valid  <= 1'b1;
        acc         <= '0;
      end else begin
        acc        <= acc + {{WIN_LOG2{1'b0}}, bus_busy};
        util_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb/tb_bus_arbiter_param.sv - directed vector bench for bus_arbiter_param
// (4 masters, MAX_HOLD=4, 16-cycle utilization window).
module tb_bus_arbiter_param;

  logic       clk;
  logic       rstn;
  logic [3:0] requests;
  logic       mode;
  logic       slave_busy;
  logic [3:0] grant;
  logic       bus_busy;
  logic [1:0] master_id;
  logic [4:0] utilization;
  logic       util_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic       mode;
    logic       sb;
    logic [3:0] g;
    logic [1:0] id;
  } vec_t;

  vec_t vq[$];

  bus_arbiter_param #(.NUM_MASTERS(4), .MAX_HOLD(4), .WIN_LOG2(4)) dut (
    .clk(clk), .rstn(rstn), .requests(requests), .mode(mode), .slave_busy(slave_busy),
    .grant(grant), .bus_busy(bus_busy), .master_id(master_id),
    .utilization(utilization), .util_valid(util_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic m, input logic s,
                     input logic [3:0] g, input logic [1:0] id);
    vec_t v;
    v.rstn = r; v.req = q; v.mode = m; v.sb = s; v.g = g; v.id = id;
    vq.push_back(v);
  endtask

  task automatic cyc(input string nm, input logic [3:0] q, input logic s,
                     input logic [3:0] g, input logic [1:0] id);
    requests = q;
    slave_busy = s;
    tick();
    chk({nm, " grant"}, 32'(grant), 32'(g));
    chk({nm, " master_id"}, 32'(master_id), 32'(id));
    chk({nm, " bus_busy"}, 32'(bus_busy), 32'(|g));
  endtask

  initial begin
    rstn = 1'b0; requests = '0; mode = 1'b0; slave_busy = 1'b0;

    // fixed priority and gap between tenures
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    add(1, 4'b1010, 0, 0, 4'b0010, 1);
    add(1, 4'b1010, 0, 0, 4'b0010, 1);
    add(1, 4'b1000, 0, 0, 4'b0000, 1);
    add(1, 4'b1000, 0, 0, 4'b1000, 3);
    add(1, 4'b1000, 0, 0, 4'b1000, 3);
    add(1, 4'b0000, 0, 0, 4'b0000, 3);
    // round robin 0,1,2,3,0 with 3-cycle tenures
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 3; k++) add(1, 4'b1111, 1, 0, 4'b0001 << m, 2'(m));
      add(1, 4'b1111 & ~(4'b0001 << m), 1, 0, 4'b0000, 2'(m));
    end
    add(1, 4'b1111, 1, 0, 4'b0001, 0);
    // reset mid-tenure while master 2 owns, then rr restarts at master 0
    add(1, 4'b1110, 1, 0, 4'b0000, 0);
    add(1, 4'b1110, 1, 0, 4'b0010, 1);
    add(1, 4'b1100, 1, 0, 4'b0000, 1);
    add(1, 4'b1100, 1, 0, 4'b0100, 2);
    add(0, 4'b1111, 1, 0, 4'b0000, 0);
    add(1, 4'b1111, 1, 0, 4'b0001, 0);
    add(1, 4'b0000, 1, 0, 4'b0000, 0);
    // timeout in fixed mode, masking for one arbitration
    for (int k = 0; k < 4; k++) add(1, 4'b0011, 0, 0, 4'b0001, 0);
    add(1, 4'b0011, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) add(1, 4'b0011, 0, 0, 4'b0010, 1);
    add(1, 4'b0011, 0, 0, 4'b0000, 1);
    for (int k = 0; k < 4; k++) add(1, 4'b0011, 0, 0, 4'b0001, 0);
    // drop coinciding with timeout is a plain release: no mask on master 0
    add(1, 4'b0010, 0, 0, 4'b0000, 0);
    add(1, 4'b0011, 0, 0, 4'b0001, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0);

    for (int k = 0; k < vq.size(); k++) begin
      rstn = vq[k].rstn; requests = vq[k].req; mode = vq[k].mode; slave_busy = vq[k].sb;
      tick();
      chk($sformatf("vec%0d grant", k), 32'(grant), 32'(vq[k].g));
      chk($sformatf("vec%0d master_id", k), 32'(master_id), 32'(vq[k].id));
      chk($sformatf("vec%0d bus_busy", k), 32'(bus_busy), 32'(|vq[k].g));
    end

    // split: master 2 split out, master 1 served meanwhile, then master 2 retried first
    mode = 1'b0;
    cyc("split own2",    4'b0100, 1'b0, 4'b0100, 2);
    cyc("split release", 4'b0110, 1'b1, 4'b0000, 2);
    cyc("split m1 win",  4'b0110, 1'b1, 4'b0010, 1);
    cyc("split m1 drop", 4'b0100, 1'b1, 4'b0000, 1);
    cyc("split masked a",4'b0100, 1'b1, 4'b0000, 1);
    cyc("split masked b",4'b0100, 1'b1, 4'b0000, 1);
    cyc("split retry",   4'b0110, 1'b0, 4'b0100, 2);
    cyc("split done",    4'b0010, 1'b0, 4'b0000, 2);
    cyc("split m1 again",4'b0010, 1'b0, 4'b0010, 1);
    cyc("split idle",    4'b0000, 1'b0, 4'b0000, 1);

    // mode change never preempts the owner
    mode = 1'b0;
    cyc("mode own0",   4'b0011, 1'b0, 4'b0001, 0);
    mode = 1'b1;
    cyc("mode keep a", 4'b0011, 1'b0, 4'b0001, 0);
    cyc("mode keep b", 4'b0011, 1'b0, 4'b0001, 0);
    cyc("mode drop",   4'b0010, 1'b0, 4'b0000, 0);
    cyc("mode rr",     4'b0011, 1'b0, 4'b0010, 1);
    cyc("mode idle",   4'b0000, 1'b0, 4'b0000, 1);

    // utilization: 10 busy cycles in a window
    rstn = 1'b0; requests = 4'b0000; mode = 1'b0;
    tick();
    chk("rst utilization", 32'(utilization), 32'd0);
    chk("rst util_valid", 32'(util_valid), 32'd0);
    rstn = 1'b1; requests = 4'b0001;
    for (int k = 0; k < 10; k++) tick();
    requests = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    chk("util early valid", 32'(util_valid), 32'd0);
    tick();
    chk("util10 value", 32'(utilization), 32'd10);
    chk("util10 valid", 32'(util_valid), 32'd1);
    tick();
    chk("util10 pulse end", 32'(util_valid), 32'd0);
    chk("util10 hold", 32'(utilization), 32'd10);

    // utilization: single owner held forever (first window loses the grant cycle)
    rstn = 1'b0;
    tick();
    rstn = 1'b1; requests = 4'b0001;
    for (int k = 0; k < 16; k++) tick();
    chk("util15 value", 32'(utilization), 32'd15);
    chk("util15 valid", 32'(util_valid), 32'd1);
    for (int k = 0; k < 16; k++) tick();
    chk("util16 value", 32'(utilization), 32'd16);
    chk("util16 valid", 32'(util_valid), 32'd1);
    chk("util16 grant", 32'(grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_param.md
BUS_ARBITER_PARAM -- requirements
Module: bus_arbiter_param

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 4, giving the number of masters (legal 2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 64, giving the maximum tenure in cycles while others wait (0 = unlimited).
REQ-003 The block SHALL have parameter WIN_LOG2, default 8, so that the utilization window is 2^WIN_LOG2 cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port requests, input, NUM_MASTERS bits: per-master bus request, level-held for the whole tenure.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = fixed priority with master 0 highest; 1 = round robin.
REQ-008 The block SHALL have port slave_busy, input, 1 bit: the addressed slave requests a split.
REQ-009 The block SHALL have port grant, output, NUM_MASTERS bits: one-hot or zero bus grant, registered.
REQ-010 The block SHALL have port bus_busy, output, 1 bit: equal to OR of grant.
REQ-011 The block SHALL have port master_id, output, clog2(NUM_MASTERS) bits: index of the granted master; holds its last value when idle.
REQ-012 The block SHALL have port utilization, output, WIN_LOG2+1 bits: busy-cycle count of the last completed window.
REQ-013 The block SHALL have port util_valid, output, 1 bit: one-cycle pulse when utilization updates.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (grant = 0) and BUSY (grant one-hot).
- In IDLE, if any eligible request is present at an edge, the winner's grant bit is set at that edge and the FSM enters BUSY. Latency from request to grant is 1 cycle.
REQ-015 In fixed-priority mode, the winner SHALL be the lowest-index eligible request.
REQ-016 In round-robin mode, the search SHALL start at (last granted index + 1) mod NUM_MASTERS; the pointer updates on every grant.
REQ-017 In BUSY, when the owner's request is sampled low, grant SHALL clear at that edge and the FSM returns to IDLE.
- This gives at least one zero-grant cycle between any two tenures.
REQ-018 The hold counter SHALL load 1 on grant and increment each BUSY cycle, saturating at MAX_HOLD.
- When it equals MAX_HOLD (MAX_HOLD > 0) and any other request is high, the owner is released regardless of its request.
- The released owner is ineligible for the next arbitration only.
REQ-019 slave_busy sampled high in BUSY SHALL release the owner at that edge and set split_pend with split_id = owner.
- The split master is ineligible while slave_busy is high.
REQ-020 When split_pend is set, slave_busy is low and requests[split_id] is high, the split master SHALL win over all others regardless of mode.
- split_pend clears on that grant, or if requests[split_id] is low at that arbitration.
REQ-021 Simultaneous events SHALL resolve in this order:
- Owner request drop and timeout in the same cycle: treat as a normal release, with no masking.
- slave_busy together with timeout: split takes precedence.
REQ-022 A second split while split_pend is set SHALL overwrite split_id.
REQ-023 The window counter SHALL count 0..2^WIN_LOG2-1 and wrap.
- The accumulator adds bus_busy every cycle.
- On the wrap cycle, utilization is loaded with accumulator + bus_busy, util_valid pulses, and the accumulator clears.
- Range is 0..2^WIN_LOG2, with no overflow.
REQ-024 A change on mode SHALL take effect at the next arbitration only; it never preempts a current owner.

Reset
REQ-025 With rstn low at an edge, the following SHALL be cleared:
- grant = 0, bus_busy = 0, master_id = 0, utilization = 0, util_valid = 0.
- FSM = IDLE, round-robin pointer = NUM_MASTERS-1 (so master 0 is searched first), split_pend = 0, hold and window counters = 0.
REQ-026 Reset asserted mid-tenure SHALL clear grant at that same edge; no state persists across reset.

Verification
REQ-027 Fixed priority: mode=0, requests=4'b1010 held -> grant=4'b0010 one cycle later; drop req1 -> grant=0 for 1 cycle, then grant=4'b1000.
REQ-028 Round robin: mode=1, requests=4'b1111, each master drops after 3 cycles of grant and re-requests -> grant order 0,1,2,3,0.
REQ-029 Timeout: MAX_HOLD=4, req0 held, req1 high -> grant0 lasts exactly 4 cycles, 1 idle cycle, then grant1 even in fixed mode.
REQ-030 Split: master 2 owns the bus, slave_busy pulses high for 5 cycles, req1 high -> grant1 while busy; after release and slave_busy low -> grant2 before master 1 re-wins.
REQ-031 Utilization: WIN_LOG2=4, bus busy 10 of 16 cycles -> utilization=10 with util_valid on cycle 16; always busy -> 16.
REQ-032 Reset: rstn low while grant=4'b0100 -> all outputs 0 at that edge; after release with requests=4'b1111, mode=1 -> grant=4'b0001 first.
